// File: rtl/simple_bus_master.sv
// simple_bus_master
//   CPU-side master for the simple_bus req/gnt/start/rdy handshake. CPU
//   commands are queued in a small FIFO. Each command is popped into a
//   command register and then run through the bus handshake. Every command
//   produces exactly one response: read data, or a timeout flag.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command push handshake (ready = !full)
//   cmd_addr, cmd_wdata, cmd_mode    command payload (mode[0]=1 is write)
//   rsp_valid, rsp_rdata, rsp_timeout  one-cycle response pulse
//   req/gnt                          bus request / grant
//   addr, mode, start                bus address, mode, transfer strobe
//   data_out, data_oe                write data and its enable
//   data_in, rdy                     read data and target-done
//   busy                             transaction in flight or commands queued
module simple_bus_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [1:0] cmd_mode,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       req,
    input  logic       gnt,
    output logic [7:0] addr,
    output logic [1:0] mode,
    output logic       start,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       rdy,
    output logic       busy
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 18;  // {mode, wdata, addr}
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_WAIT,
        S_RSP
    } state_t;

    state_t state_q, state_d;

    // ---------------- command FIFO ----------------
    logic [EW-1:0] fifo_mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // differing only in the wrap bit mean full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready depends only on the current fill level, so a pop in the same
    // cycle never makes room for a push.
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign cmd_ready = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_mode, cmd_wdata, cmd_addr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // ---------------- current command ----------------
    logic [EW-1:0] cmd_q;
    logic [7:0]    cur_addr, cur_wdata;
    logic [1:0]    cur_mode;
    logic          cur_write;

    assign cur_addr  = cmd_q[7:0];
    assign cur_wdata = cmd_q[15:8];
    assign cur_mode  = cmd_q[17:16];
    assign cur_write = cur_mode[0];

    // ---------------- handshake FSM ----------------
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]    rsp_rdata_d;
    logic          rsp_timeout_d;
    logic          xfer_d;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = 8'h00;
        rsp_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_REQ;
            end
            S_REQ: begin
                if (gnt) state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // rdy takes priority over expiry in the same cycle
                if (rdy) begin
                    state_d     = S_RSP;
                    rsp_rdata_d = cur_write ? 8'h00 : data_in;
                end else if (cnt_inc == TO_VAL) begin
                    state_d       = S_RSP;
                    rsp_timeout_d = 1'b1;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus-side fields are driven from START through the end of WAIT.
    assign xfer_d = (state_d == S_START) || (state_d == S_WAIT);

    logic       req_q, start_q, data_oe_q, rsp_valid_q, rsp_timeout_q;
    logic [7:0] addr_q, data_out_q, rsp_rdata_q;
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_q         <= '0;
            req_q         <= 1'b0;
            start_q       <= 1'b0;
            addr_q        <= 8'h00;
            mode_q        <= 2'b00;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) cmd_q <= fifo_mem[rd_ptr_q[AW-1:0]];
            // Outputs are registered from the next state so they line up
            // with the state they belong to.
            req_q         <= (state_d == S_REQ);
            start_q       <= (state_d == S_START);
            addr_q        <= xfer_d ? cur_addr : 8'h00;
            mode_q        <= xfer_d ? cur_mode : 2'b00;
            data_out_q    <= (xfer_d && cur_write) ? cur_wdata : 8'h00;
            data_oe_q     <= xfer_d && cur_write;
            rsp_valid_q   <= (state_d == S_RSP);
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req         = req_q;
    assign start       = start_q;
    assign addr        = addr_q;
    assign mode        = mode_q;
    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: doc/simple_bus_master.md
# simple_bus_master

CPU-side bus master for the `simple_bus` interface. It sits directly upstream of the memory-side grant logic and feeds it transactions. It accepts read/write commands from a CPU core through a small command FIFO and runs the bus req/gnt/start/rdy handshake for each one. It returns one response per command, with read data or a timeout flag.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO entries; a power of 2, ≥2.
- `TIMEOUT`, 16: cycles to wait for `rdy` after `start` before aborting; ≥1.

Ports:
- `clk`  in  1  bus clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; `cmd_ready = !full`.
- `cmd_addr`  in  8  target address.
- `cmd_wdata`  in  8  write data; ignored for reads.
- `cmd_mode`  in  2  bus mode; `mode[0]=1` is write, `mode[0]=0` is read; `mode[1]` is passed through unchanged.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  8  read data captured on `rdy`; 0 for writes and timeouts.
- `rsp_timeout`  out  1  qualifies `rsp_valid`; transaction aborted.
- `req`  out  1  bus request.
- `gnt`  in  1  bus grant.
- `addr`  out  8  bus address.
- `mode`  out  2  bus mode.
- `start`  out  1  one-cycle transfer strobe.
- `data_out`  out  8  write data driven to the bus.
- `data_oe`  out  1  `data_out` valid (write transfers).
- `data_in`  in  8  read data from the bus.
- `rdy`  in  1  target done.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- A push occurs on `cmd_valid && cmd_ready`.
- When the FIFO is full, `cmd_ready=0`. A same-cycle pop does not enable a push.
- FSM states and transitions:
  - IDLE → REQ when the FIFO is non-empty. The head entry is popped into a command register.
  - REQ: `req=1`, held until `gnt` is sampled 1, then → START.
  - START: `start=1` for exactly one cycle. `addr`/`mode`/`data_out`/`data_oe` carry the command. `req` drops in this cycle. → WAIT.
  - WAIT: the timeout counter increments each cycle.
    - `rdy=1` → RSP; `data_in` is captured if the command is a read.
    - Counter reaches `TIMEOUT` with `rdy=0` → RSP with the timeout flag set.
    - `rdy` and counter expiry in the same cycle: `rdy` wins; not a timeout.
  - RSP: `rsp_valid=1` for one cycle → IDLE.
- `addr`/`mode`/`data_out`/`data_oe` hold their value from START until leaving WAIT, and are 0 otherwise.
- `rdy` arriving in IDLE, REQ or START is ignored.
- `gnt` is sampled only in REQ.
- The counter is wide enough for `TIMEOUT` ($clog2(TIMEOUT+1)) and is cleared on entering WAIT.
- FIFO pointers are `log2(CMD_DEPTH)+1` bits and wrap naturally. Full and empty are distinguished by the MSB.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from registers.
- Reset values (asynchronous on `rst_n=0`):
  - FSM = IDLE; FIFO empty.
  - `cmd_ready=1`, `busy=0`.
  - All other outputs 0.
- Reset mid-transaction aborts immediately: `req`/`start` drop in the same instant, no response is emitted, and queued commands are discarded.
- Minimum latency, with the FIFO empty and `gnt` tied high:
  - E0: push.
  - E1: IDLE→REQ; `req=1`.
  - E2: `gnt` seen; START; `start=1`.
  - E3: WAIT.
  - `rdy` sampled at E4 at the earliest → RSP. `rsp_valid` is high in the cycle after E4.
- Back-to-back: a command is popped in the cycle after RSP, so there is at least one IDLE cycle between transactions.
- Timeout: with `rdy` never asserted, `rsp_valid` with `rsp_timeout=1` occurs `TIMEOUT+1` cycles after the start cycle.

## Test plan
- Single write: addr=0x3C, wdata=0xA5, mode=01, gnt tied 1, rdy at E4.
  - Expect `start` high exactly 1 cycle with addr=0x3C, data_out=0xA5, data_oe=1.
  - `rsp_valid` pulses once with rsp_rdata=0x00 and rsp_timeout=0.
- Read with delayed grant: mode=00, addr=0x10; gnt held low 5 cycles; data_in=0x5A with rdy 3 cycles after start.
  - `req` stays high for all 5 cycles.
  - Expect rsp_rdata=0x5A and data_oe=0.
- FIFO full: 5 pushes with gnt=0 and CMD_DEPTH=4.
  - `cmd_ready` drops after the 5th accepted command (1 in the FSM + 4 queued), and the 6th is stalled.
  - Release gnt: 5 responses in push order.
- Timeout: TIMEOUT=16, rdy never asserted.
  - `rsp_timeout=1` and rsp_rdata=0 at 17 cycles after start.
  - Next command proceeds normally.
- Race: rdy asserted in the same cycle the counter reaches TIMEOUT.
  - Expect rsp_timeout=0 and data captured.
- Reset during WAIT with 2 commands queued.
  - All outputs 0, `cmd_ready=1`, `busy=0`, and no rsp_valid after reset releases.
